// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequencing controller and two-requester round-robin arbiter
// for the LC-3 memory subsystem (MAR/MDR plus synchronous RAM port A).
// Ports:
//   clk, reset               : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata    : CPU single-transaction request port
//   cpu_ack                  : one-cycle completion pulse to the CPU
//   ld_req/we/addr/wdata     : program-loader request port
//   ld_ack                   : one-cycle completion pulse to the loader
//   rdata                    : read data, valid while an ack is high for a read
//   MDROut                   : current MDR contents from the memory block
//   busOut, busEn            : value for the Bus and its gate enable
//   ldMAR, ldMDR, selMDR     : MAR/MDR load strobes and MDR input select
//   memWE                    : RAM port-A write enable
//   busy, grant              : not-idle flag and owner of current/last transaction
module mem_access_ctrl #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_wdata,
  output logic        ld_ack,
  output logic [15:0] rdata,
  input  logic [15:0] MDROut,
  output logic [15:0] busOut,
  output logic        busEn,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        memWE,
  output logic        busy,
  output logic        grant
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_MAR, S_RWAIT, S_RMDR, S_WMDR, S_WRITE, S_DONE
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               last_gnt, gnt_d, take, pick_ld;
  logic               we_q;
  logic [15:0]        wdata_q, rdata_q, sel_addr;
  logic [15:0]        bus_d;
  logic               bus_en_d, ld_mar_d, ld_mdr_d, sel_mdr_d, mem_we_d;
  logic               cpu_ack_d, ld_ack_d, busy_d;

  // Round-robin on a tie: the port that was not granted last wins.
  assign pick_ld  = (cpu_req && ld_req) ? ~last_gnt : ld_req;
  assign sel_addr = pick_ld ? ld_addr : cpu_addr;

  // Next state, then all Moore outputs decoded from the next state so they
  // can be registered and appear cleanly in the state they belong to.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    gnt_d     = grant;
    take      = 1'b0;
    bus_d     = 16'h0000;
    bus_en_d  = 1'b0;
    ld_mar_d  = 1'b0;
    ld_mdr_d  = 1'b0;
    sel_mdr_d = 1'b0;
    mem_we_d  = 1'b0;
    cpu_ack_d = 1'b0;
    ld_ack_d  = 1'b0;

    case (state)
      S_IDLE: begin
        if (cpu_req || ld_req) begin
          take    = 1'b1;
          gnt_d   = pick_ld;
          state_d = S_MAR;
        end
      end
      S_MAR: begin
        if (we_q) begin
          state_d = S_WMDR;
        end else begin
          state_d = S_RWAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      S_RWAIT: begin
        if (cnt == '0) state_d = S_RMDR;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      S_RMDR:  state_d = S_DONE;
      S_WMDR:  state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_MAR: begin
        // MAR is only entered from IDLE, so the address comes straight from the winning port.
        bus_en_d = 1'b1;
        bus_d    = sel_addr;
        ld_mar_d = 1'b1;
      end
      S_WMDR: begin
        bus_en_d = 1'b1;
        bus_d    = wdata_q;
        ld_mdr_d = 1'b1;
      end
      S_RMDR: begin
        sel_mdr_d = 1'b1;
        ld_mdr_d  = 1'b1;
      end
      S_WRITE: mem_we_d = 1'b1;
      S_DONE: begin
        cpu_ack_d = ~gnt_d;
        ld_ack_d  = gnt_d;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
      grant    <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= 16'h0000;
      rdata_q  <= 16'h0000;
      busOut   <= 16'h0000;
      busEn    <= 1'b0;
      ldMAR    <= 1'b0;
      ldMDR    <= 1'b0;
      selMDR   <= 1'b0;
      memWE    <= 1'b0;
      cpu_ack  <= 1'b0;
      ld_ack   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      grant   <= gnt_d;
      busOut  <= bus_d;
      busEn   <= bus_en_d;
      ldMAR   <= ld_mar_d;
      ldMDR   <= ld_mdr_d;
      selMDR  <= sel_mdr_d;
      memWE   <= mem_we_d;
      cpu_ack <= cpu_ack_d;
      ld_ack  <= ld_ack_d;
      busy    <= busy_d;
      if (take) begin
        last_gnt <= pick_ld;
        we_q     <= pick_ld ? ld_we : cpu_we;
        wdata_q  <= pick_ld ? ld_wdata : cpu_wdata;
      end
      if (state == S_DONE && !we_q) rdata_q <= MDROut;
    end
  end

  // MDR only picks up the RAM word on the edge that enters DONE, so during
  // the ack cycle of a read the fresh MDR value is passed through directly;
  // afterwards the captured copy holds until the next read completes.
  assign rdata = (state == S_DONE && !we_q) ? MDROut : rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (RD_LAT=1 and RD_LAT=3), each with
// its own MAR/MDR/RAM model, table-driven per-cycle vectors plus hand sequences.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, init;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [15:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;

  logic        cpu_ack1, ld_ack1, bus_en1, ld_mar1, ld_mdr1, sel_mdr1, mem_we1, busy1, grant1;
  logic [15:0] rdata1, bus_out1, mdr1, mar1, bus1;
  logic        cpu_ack3, ld_ack3, bus_en3, ld_mar3, ld_mdr3, sel_mdr3, mem_we3, busy3, grant3;
  logic [15:0] rdata3, bus_out3, mdr3, mar3, bus3;
  logic [15:0] ram1 [0:255];
  logic [15:0] ram3 [0:255];

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.RD_LAT(1)) u1 (
    .clk(clk), .reset(rst1),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack1),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack1),
    .rdata(rdata1), .MDROut(mdr1), .busOut(bus_out1), .busEn(bus_en1),
    .ldMAR(ld_mar1), .ldMDR(ld_mdr1), .selMDR(sel_mdr1), .memWE(mem_we1),
    .busy(busy1), .grant(grant1));

  mem_access_ctrl #(.RD_LAT(3)) u3 (
    .clk(clk), .reset(rst3),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack3),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack3),
    .rdata(rdata3), .MDROut(mdr3), .busOut(bus_out3), .busEn(bus_en3),
    .ldMAR(ld_mar3), .ldMDR(ld_mdr3), .selMDR(sel_mdr3), .memWE(mem_we3),
    .busy(busy3), .grant(grant3));

  assign bus1 = bus_en1 ? bus_out1 : 16'h0000;
  assign bus3 = bus_en3 ? bus_out3 : 16'h0000;

  // Memory block models: registered MAR, MDR with RAM/Bus mux, RAM with unregistered q.
  always @(posedge clk) begin
    if (init) begin
      ram1[8'h00] <= 16'h1234;
      ram3[8'h00] <= 16'h1234;
      ram3[8'h02] <= 16'h5A5A;
    end else begin
      if (ld_mar1) mar1 <= bus1;
      if (ld_mdr1) mdr1 <= sel_mdr1 ? ram1[mar1[7:0]] : bus1;
      if (mem_we1) ram1[mar1[7:0]] <= mdr1;
      if (ld_mar3) mar3 <= bus3;
      if (ld_mdr3) mdr3 <= sel_mdr3 ? ram3[mar3[7:0]] : bus3;
      if (mem_we3) ram3[mar3[7:0]] <= mdr3;
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h (t=%0t)", nm, idx, act, exp, $time);
    end
  endtask

  // Safety properties checked every cycle on both instances.
  always @(negedge clk) begin
    if (!init) begin
      chk("we_excl1",  0, 32'(mem_we1 & (ld_mar1 | ld_mdr1)), 32'd0);
      chk("ack_excl1", 0, 32'(cpu_ack1 & ld_ack1), 32'd0);
      chk("busen1",    0, 32'(bus_en1 & ~(ld_mar1 | (ld_mdr1 & ~sel_mdr1))), 32'd0);
      chk("we_excl3",  0, 32'(mem_we3 & (ld_mar3 | ld_mdr3)), 32'd0);
      chk("ack_excl3", 0, 32'(cpu_ack3 & ld_ack3), 32'd0);
      chk("busen3",    0, 32'(bus_en3 & ~(ld_mar3 | (ld_mdr3 & ~sel_mdr3))), 32'd0);
    end
  end

  // Strobe vector order: {busEn, ldMAR, ldMDR, selMDR, memWE, cpu_ack, ld_ack, busy}
  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic        ld_req;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [7:0]  exp_s;
    logic        exp_grant;
    logic [15:0] exp_bus;
    logic        chk_rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [0:39];
  int   nv = 0;

  task automatic add(input logic cr, input logic cw, input logic lr, input logic [15:0] a,
                     input logic [15:0] d, input logic [7:0] s, input logic g,
                     input logic [15:0] b, input logic ck, input logic [15:0] rd);
    vecs[nv].cpu_req = cr;  vecs[nv].cpu_we = cw;  vecs[nv].ld_req = lr;
    vecs[nv].addr = a;      vecs[nv].wdata = d;    vecs[nv].exp_s = s;
    vecs[nv].exp_grant = g; vecs[nv].exp_bus = b;  vecs[nv].chk_rd = ck;
    vecs[nv].exp_rd = rd;
    nv++;
  endtask

  task automatic add_read(input logic ld, input logic g0, input logic [15:0] a, input logic [15:0] d);
    add(~ld,  1'b0, ld,   a, 16'h0, 8'h00, g0, 16'h0, 1'b0, 16'h0);
    add(1'b0, 1'b0, 1'b0, a, 16'h0, 8'hC1, ld, a,     1'b0, 16'h0);
    add(1'b0, 1'b0, 1'b0, a, 16'h0, 8'h01, ld, 16'h0, 1'b0, 16'h0);
    add(1'b0, 1'b0, 1'b0, a, 16'h0, 8'h31, ld, 16'h0, 1'b0, 16'h0);
    add(1'b0, 1'b0, 1'b0, a, 16'h0, ld ? 8'h03 : 8'h05, ld, 16'h0, 1'b1, d);
    add(1'b0, 1'b0, 1'b0, a, 16'h0, 8'h00, ld, 16'h0, 1'b1, d);
  endtask

  task automatic add_write(input logic [15:0] a, input logic [15:0] d);
    add(1'b1, 1'b1, 1'b0, a, d, 8'h00, 1'b0, 16'h0, 1'b0, 16'h0);
    add(1'b0, 1'b0, 1'b0, a, d, 8'hC1, 1'b0, a,     1'b0, 16'h0);
    add(1'b0, 1'b0, 1'b0, a, d, 8'hA1, 1'b0, d,     1'b0, 16'h0);
    add(1'b0, 1'b0, 1'b0, a, d, 8'h09, 1'b0, 16'h0, 1'b0, 16'h0);
    add(1'b0, 1'b0, 1'b0, a, d, 8'h05, 1'b0, 16'h0, 1'b0, 16'h0);
    add(1'b0, 1'b0, 1'b0, a, d, 8'h00, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  // Applies rows to the RD_LAT=1 instance; entered and left at posedge+1.
  task automatic run_rows(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      cpu_req   = vecs[i].cpu_req;
      cpu_we    = vecs[i].cpu_we;
      cpu_addr  = vecs[i].addr;
      cpu_wdata = vecs[i].wdata;
      ld_req    = vecs[i].ld_req;
      ld_addr   = vecs[i].addr;
      #1;
      chk("strobes", i, 32'({bus_en1, ld_mar1, ld_mdr1, sel_mdr1, mem_we1, cpu_ack1, ld_ack1, busy1}),
          32'(vecs[i].exp_s));
      chk("grant", i, 32'(grant1), 32'(vecs[i].exp_grant));
      if (vecs[i].exp_s[7]) chk("busOut", i, 32'(bus_out1), 32'(vecs[i].exp_bus));
      if (vecs[i].chk_rd)   chk("rdata", i, 32'(rdata1), 32'(vecs[i].exp_rd));
      @(posedge clk); #1;
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e3 [0:7];
    logic [3:0] gseq;
    int ncpu, nld, ng;

    add_read(1'b0, 1'b0, 16'h3000, 16'h1234);   // rows 0..5
    add_write(16'h3001, 16'hBEEF);              // rows 6..11
    add_read(1'b0, 1'b0, 16'h3001, 16'hBEEF);   // rows 12..17
    add_read(1'b1, 1'b0, 16'h3000, 16'h1234);   // rows 18..23

    init = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    ld_req = 1'b0;  ld_we = 1'b0;  ld_addr = 16'h0;  ld_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    init = 1'b0; rst1 = 1'b0;

    // Reset then idle: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_strobes", i, 32'({bus_en1, ld_mar1, ld_mdr1, sel_mdr1, mem_we1, cpu_ack1, ld_ack1, busy1}), 32'd0);
      chk("idle_grant", i, 32'(grant1), 32'd0);
      chk("idle_rdata", i, 32'(rdata1), 32'd0);
    end

    run_rows(0, nv);

    // Both ports request together, each for two reads: grants alternate 0,1,0,1.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 16'h3001;
    ncpu = 0; nld = 0; ng = 0; gseq = 4'h0;
    for (int cyc = 0; cyc < 80 && (ncpu < 2 || nld < 2); cyc++) begin
      #1;
      if (ld_mar1) begin
        if (ng < 4) gseq[ng] = grant1;
        ng++;
      end
      if (cpu_ack1) begin
        chk("rr_cpu_rdata", ncpu, 32'(rdata1), 32'h1234);
        ncpu++;
        if (ncpu == 2) cpu_req = 1'b0;
      end
      if (ld_ack1) begin
        chk("rr_ld_rdata", nld, 32'(rdata1), 32'hBEEF);
        nld++;
        if (nld == 2) ld_req = 1'b0;
      end
      tick();
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    chk("rr_cpu_count", 0, 32'(ncpu), 32'd2);
    chk("rr_ld_count", 0, 32'(nld), 32'd2);
    chk("rr_grants", 0, 32'(ng), 32'd4);
    chk("rr_grant_seq", 0, 32'(gseq), 32'hA);
    tick();

    // Reset during RWAIT aborts the read silently.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    tick(); cpu_req = 1'b0;
    tick(); #1;
    chk("rwait_busy", 0, 32'({ld_mar1, ld_mdr1, busy1}), 32'd1);
    rst1 = 1'b1;
    tick(); rst1 = 1'b0; #1;
    chk("rst_rwait", 0, 32'({bus_en1, ld_mar1, ld_mdr1, sel_mdr1, mem_we1, cpu_ack1, ld_ack1, busy1}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_rwait_noack", i, 32'({cpu_ack1, ld_ack1, busy1}), 32'd0);
    end

    // Reset during WRITE aborts the write with no ack.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3003; cpu_wdata = 16'h1111;
    tick(); cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    tick(); #1;
    chk("write_cycle", 0, 32'(mem_we1), 32'd1);
    rst1 = 1'b1;
    tick(); rst1 = 1'b0; #1;
    chk("rst_write", 0, 32'({bus_en1, ld_mar1, ld_mdr1, sel_mdr1, mem_we1, cpu_ack1, ld_ack1, busy1}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_write_noack", i, 32'({cpu_ack1, ld_ack1, busy1}), 32'd0);
    end

    // Normal read after the aborted transactions.
    run_rows(0, 6);

    // RD_LAT=3 instance: three RWAIT cycles, ack in cycle 6.
    rst3 = 1'b0;
    tick();
    e3[0] = 8'h00; e3[1] = 8'hC1; e3[2] = 8'h01; e3[3] = 8'h01;
    e3[4] = 8'h01; e3[5] = 8'h31; e3[6] = 8'h05; e3[7] = 8'h00;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3002;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("lat3_strobes", i, 32'({bus_en3, ld_mar3, ld_mdr3, sel_mdr3, mem_we3, cpu_ack3, ld_ack3, busy3}),
          32'(e3[i]));
      if (i == 1) chk("lat3_bus", i, 32'(bus_out3), 32'h3002);
      if (i == 6) chk("lat3_rdata", i, 32'(rdata3), 32'h5A5A);
      if (i == 6) chk("lat3_grant", i, 32'(grant3), 32'd0);
      tick();
      cpu_req = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
